vmicro16_apb_rr_arbiter: RTL

- Round-robin arbiter that shares one upstream APB master port between MASTER_PORTS core-side APB masters.
- Sits between the per-core APB master interfaces and the shared peripheral address decoder/bus.
- Serialises transfers through a SETUP/ACCESS state machine.
- Includes a PREADY watchdog so a hung slave cannot stall every core.

---
 rtl/vmicro16_apb_rr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter multiplexing several core-side APB masters onto one
// upstream APB port, with a PREADY watchdog so a hung slave cannot block the bus.
module vmicro16_apb_rr_arbiter #(
  parameter int                   MASTER_PORTS   = 2,
  parameter int                   BUS_WIDTH      = 16,
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [BUS_WIDTH-1:0] TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic                              M_PSEL,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  output logic [MASTER_PORTS-1:0]           grant,
  output logic                              timeout_err
);

  localparam int OW      = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int WW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WW-1:0] WD_LIM = WW'(WD_LAST);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] owner, last_owner, pick, rr_idx;
  logic          found;
  logic [WW-1:0] wd_cnt;
  logic          wd_fire, done;

  function automatic logic [OW-1:0] wrap(input int v);
    return OW'(v % MASTER_PORTS);
  endfunction

  function automatic logic [MASTER_PORTS-1:0] onehot(input logic [OW-1:0] i);
    logic [MASTER_PORTS-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Scan starts just after the previous owner, so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      rr_idx = wrap(int'(last_owner) + k);
      if (!found && S_PSELx[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    wd_fire     = 1'b0;
    done        = 1'b0;
    S_PREADY    = '0;
    S_PRDATA    = '0;
    timeout_err = 1'b0;
    M_PSEL      = (state != IDLE);
    M_PENABLE   = (state == ACCESS);
    case (state)
      IDLE:   if (found) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        // A ready on the limit cycle wins over the watchdog.
        wd_fire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIM) && !M_PREADY;
        done    = M_PREADY || wd_fire;
        if (done) begin
          state_nxt = IDLE;
          // Completion is suppressed while reset is held so an aborted
          // transfer never reports ready to its core.
          if (reset) begin
            S_PREADY[owner] = 1'b1;
            S_PRDATA[int'(owner)*BUS_WIDTH +: BUS_WIDTH] = M_PREADY ? M_PRDATA : TIMEOUT_DATA;
            timeout_err = wd_fire;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(MASTER_PORTS - 1);
      grant      <= '0;
      M_PADDR    <= '0;
      M_PWDATA   <= '0;
      M_PWRITE   <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          owner    <= pick;
          grant    <= onehot(pick);
          M_PADDR  <= S_PADDR[int'(pick)*BUS_WIDTH +: BUS_WIDTH];
          M_PWDATA <= S_PWDATA[int'(pick)*BUS_WIDTH +: BUS_WIDTH];
          M_PWRITE <= S_PWRITE[pick];
        end
        ACCESS: begin
          if (done) begin
            last_owner <= owner;
            grant      <= '0;
            wd_cnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
